// File: rtl/dac_tx.sv
// Parallel 8-bit DAC transmitter: divides the system clock into the DAC conversion
// clock and feeds samples from a small FIFO onto the DAC bus ahead of each rising edge.
module dac_tx #(
  parameter int         CLK_DIV   = 4,
  parameter int         CNT_W     = 2,
  parameter int         ADDR_W    = 3,
  parameter logic [7:0] IDLE_CODE = 8'h80
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [7:0]        i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [7:0]        o_dac_data,
  output logic              o_dac_clk,
  output logic              o_underrun,
  output logic [ADDR_W:0]   o_level
);

  localparam int                DEPTH       = 1 << ADDR_W;
  localparam int                HALF        = CLK_DIV / 2;
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF    = CNT_W'(HALF);
  localparam logic [ADDR_W:0]   LEVEL_FULL  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEVEL_EMPTY = {(ADDR_W+1){1'b0}};

  logic [CNT_W-1:0]  cnt_r;
  logic              dac_clk_r;
  logic [7:0]        dac_data_r;
  logic              underrun_r;
  logic [7:0]        mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   level_r;

  logic [CNT_W-1:0]  cnt_next_s;
  logic              slot_s;
  logic              ready_s;
  logic              push_s;
  logic              pop_s;
  logic              starve_s;

  // Next divider count, slot detection and FIFO handshake decode
  always_comb begin
    cnt_next_s = {CNT_W{1'b0}};
    slot_s     = 1'b0;
    if (i_en) begin
      if (cnt_r == CNT_LAST) begin
        slot_s     = 1'b1;
        cnt_next_s = {CNT_W{1'b0}};
      end else begin
        slot_s     = 1'b0;
        cnt_next_s = cnt_r + 1'b1;
      end
    end else begin
      slot_s     = 1'b0;
      cnt_next_s = {CNT_W{1'b0}};
    end
    // Slot decisions use the registered level, so a same-edge push is never visible
    ready_s  = (level_r != LEVEL_FULL);
    push_s   = i_valid && ready_s && !i_rst;
    pop_s    = slot_s && (level_r != LEVEL_EMPTY);
    starve_s = slot_s && (level_r == LEVEL_EMPTY);
  end

  // Divider counter and DAC clock, both derived from the same next count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_r     <= {CNT_W{1'b0}};
      dac_clk_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_next_s;
      dac_clk_r <= (cnt_next_s >= CNT_HALF);
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      level_r  <= LEVEL_EMPTY;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= i_data;
    end
  end

  // DAC data bus and underrun pulse, updated only at sample slots
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dac_data_r <= IDLE_CODE;
      underrun_r <= 1'b0;
    end else begin
      if (pop_s) begin
        dac_data_r <= mem_r[rd_ptr_r];
      end
      underrun_r <= starve_s;
    end
  end

  assign o_ready    = ready_s;
  assign o_dac_data = dac_data_r;
  assign o_dac_clk  = dac_clk_r;
  assign o_underrun = underrun_r;
  assign o_level    = level_r;

endmodule

// File: tb/tb_dac_tx.sv
// Directed self-checking bench for dac_tx (CLK_DIV=4, depth 8): divider, streaming,
// full/underrun guards, simultaneous push/pop and mid-stream reset.
module tb_dac_tx;

  logic       i_clk;
  logic       i_rst;
  logic       i_en;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] o_dac_data;
  logic       o_dac_clk;
  logic       o_underrun;
  logic [3:0] o_level;

  int checks = 0;
  int errors = 0;

  dac_tx dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_dac_data (o_dac_data),
    .o_dac_clk  (o_dac_clk),
    .o_underrun (o_underrun),
    .o_level    (o_level)
  );

  initial i_clk = 1'b0;
  always #10 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  initial begin
    // Reset held 3 cycles with enable and valid active
    i_rst = 1'b1; i_en = 1'b1; i_valid = 1'b1; i_data = 8'hAA;
    tick(3);
    chk("rst_data", 32'(o_dac_data), 32'h80);
    chk("rst_clk", 32'(o_dac_clk), 32'h0);
    chk("rst_level", 32'(o_level), 32'h0);
    chk("rst_ready", 32'(o_ready), 32'h1);
    chk("rst_underrun", 32'(o_underrun), 32'h0);

    // Divider pattern after release; empty FIFO underruns at each wrap
    i_rst = 1'b0; i_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick(1);
      chk("div_clk", 32'(o_dac_clk), ((n % 4) >= 2) ? 32'h1 : 32'h0);
      chk("div_underrun", 32'(o_underrun), ((n % 4) == 0) ? 32'h1 : 32'h0);
      chk("div_data", 32'(o_dac_data), 32'h80);
    end

    // Stream 10,20,30 back-to-back
    i_valid = 1'b1; i_data = 8'h10;
    tick(1); chk("str_level1", 32'(o_level), 32'h1);
    i_data = 8'h20;
    tick(1); chk("str_level2", 32'(o_level), 32'h2);
    i_data = 8'h30;
    tick(1); chk("str_level3", 32'(o_level), 32'h3);
    i_valid = 1'b0;
    tick(1);
    chk("str_data10", 32'(o_dac_data), 32'h10);
    chk("str_level_a", 32'(o_level), 32'h2);
    chk("str_clk_fall", 32'(o_dac_clk), 32'h0);
    tick(1);
    chk("str_setup_clk", 32'(o_dac_clk), 32'h0);
    chk("str_setup_data", 32'(o_dac_data), 32'h10);
    tick(1);
    chk("str_rise_clk", 32'(o_dac_clk), 32'h1);
    chk("str_rise_data", 32'(o_dac_data), 32'h10);
    tick(2);
    chk("str_data20", 32'(o_dac_data), 32'h20);
    chk("str_level_b", 32'(o_level), 32'h1);
    tick(4);
    chk("str_data30", 32'(o_dac_data), 32'h30);
    chk("str_level_c", 32'(o_level), 32'h0);
    chk("str_no_underrun", 32'(o_underrun), 32'h0);
    tick(4);
    chk("str_underrun", 32'(o_underrun), 32'h1);
    chk("str_hold30", 32'(o_dac_data), 32'h30);

    // Fill with clock parked: 9 pushes, 9th dropped
    i_en = 1'b0; i_valid = 1'b1;
    for (int w = 1; w <= 9; w++) begin
      i_data = 8'(w);
      tick(1);
      chk("full_level", 32'(o_level), (w <= 8) ? 32'(w) : 32'h8);
      chk("full_ready", 32'(o_ready), (w < 8) ? 32'h1 : 32'h0);
      chk("full_parked_clk", 32'(o_dac_clk), 32'h0);
      chk("full_no_underrun", 32'(o_underrun), 32'h0);
    end
    chk("full_hold30", 32'(o_dac_data), 32'h30);
    i_valid = 1'b0; i_en = 1'b1;
    tick(1); chk("en_clk0", 32'(o_dac_clk), 32'h0);
    tick(1); chk("en_clk1", 32'(o_dac_clk), 32'h1);
    tick(2);
    chk("drain_ready", 32'(o_ready), 32'h1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick(4);
      chk("drain_data", 32'(o_dac_data), 32'(k + 1));
      chk("drain_level", 32'(o_level), 32'(7 - k));
      chk("drain_no_underrun", 32'(o_underrun), 32'h0);
    end
    tick(4);
    chk("drain_underrun", 32'(o_underrun), 32'h1);
    chk("drain_hold08", 32'(o_dac_data), 32'h08);

    // Underrun pulses once per period; push at a slot edge still underruns
    tick(1); chk("ur_pulse_end", 32'(o_underrun), 32'h0);
    tick(3); chk("ur_pulse2", 32'(o_underrun), 32'h1);
    tick(1); chk("ur_pulse2_end", 32'(o_underrun), 32'h0);
    tick(2);
    i_valid = 1'b1; i_data = 8'h5A;
    tick(1);
    i_valid = 1'b0;
    chk("ur_slot_push_underrun", 32'(o_underrun), 32'h1);
    chk("ur_slot_push_data", 32'(o_dac_data), 32'h08);
    chk("ur_slot_push_level", 32'(o_level), 32'h1);
    tick(4);
    chk("ur_next_data", 32'(o_dac_data), 32'h5A);
    chk("ur_next_level", 32'(o_level), 32'h0);
    chk("ur_next_no_underrun", 32'(o_underrun), 32'h0);

    // Level 4, push coincident with a pop
    i_en = 1'b0; i_valid = 1'b1;
    i_data = 8'hA1; tick(1);
    i_data = 8'hA2; tick(1);
    i_data = 8'hA3; tick(1);
    i_data = 8'hA4; tick(1);
    i_valid = 1'b0; i_en = 1'b1;
    tick(3);
    chk("sim_level_pre", 32'(o_level), 32'h4);
    i_valid = 1'b1; i_data = 8'hB5;
    tick(1);
    i_valid = 1'b0;
    chk("sim_level_same", 32'(o_level), 32'h4);
    chk("sim_dataA1", 32'(o_dac_data), 32'hA1);
    tick(4); chk("sim_dataA2", 32'(o_dac_data), 32'hA2);
    tick(4); chk("sim_dataA3", 32'(o_dac_data), 32'hA3);
    tick(4); chk("sim_dataA4", 32'(o_dac_data), 32'hA4);
    tick(4);
    chk("sim_dataB5", 32'(o_dac_data), 32'hB5);
    chk("sim_level_end", 32'(o_level), 32'h0);

    // Reset mid-stream with level 5 and DAC clock high
    i_en = 1'b0; i_valid = 1'b1;
    for (int w = 0; w < 5; w++) begin
      i_data = 8'hC1 + 8'(w);
      tick(1);
    end
    i_valid = 1'b0; i_en = 1'b1;
    tick(2);
    chk("mid_clk_high", 32'(o_dac_clk), 32'h1);
    chk("mid_level5", 32'(o_level), 32'h5);
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    chk("mid_rst_level", 32'(o_level), 32'h0);
    chk("mid_rst_data", 32'(o_dac_data), 32'h80);
    chk("mid_rst_clk", 32'(o_dac_clk), 32'h0);
    chk("mid_rst_ready", 32'(o_ready), 32'h1);
    tick(1); chk("mid_cnt1_clk", 32'(o_dac_clk), 32'h0);
    tick(1); chk("mid_cnt2_clk", 32'(o_dac_clk), 32'h1);
    tick(1); chk("mid_cnt3_clk", 32'(o_dac_clk), 32'h1);
    tick(1);
    chk("mid_wrap_clk", 32'(o_dac_clk), 32'h0);
    chk("mid_wrap_underrun", 32'(o_underrun), 32'h1);
    chk("mid_wrap_data", 32'(o_dac_data), 32'h80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_tx.md
Name: dac_tx

Overview:
- Transmit-side counterpart of the parallel ADC capture path: drives an 8-bit parallel-input video/audio DAC.
- Generates the DAC conversion clock from the 50 MHz system clock and buffers samples from upstream logic in a small FIFO.
- Each FIFO word is presented on the DAC bus with a half-period setup before the DAC's latching rising edge.
- Sits between the sample-producing logic (valid/ready stream) and the board DAC pins.

Parameters:
- CLK_DIV, 4, system clocks per DAC clock period; minimum 2. 50 MHz / 4 = 12.5 MHz. HALF = floor(CLK_DIV/2).
- CNT_W, 2, width of divider counter; must hold CLK_DIV-1.
- ADDR_W, 3, FIFO address width; depth = 2**ADDR_W (8).
- IDLE_CODE, 8'h80, DAC code driven after reset (midscale).

Ports:
- i_clk  input  1  system clock, 50 MHz; all logic on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_en  input  1  1 = DAC clock runs and samples are consumed; 0 = DAC clock parked low.
- i_data  input  8  sample from upstream.
- i_valid  input  1  i_data valid this cycle.
- o_ready  output  1  FIFO can accept a word this cycle.
- o_dac_data  output  8  registered DAC data bus.
- o_dac_clk  output  1  registered DAC clock; DAC latches on rising edge.
- o_underrun  output  1  one-cycle pulse: sample slot with empty FIFO.
- o_level  output  ADDR_W+1  current FIFO occupancy, 0..2**ADDR_W.

Behaviour:
- Reset (i_rst=1 at a rising edge, regardless of state):
  - divider count = 0, o_dac_clk = 0, o_dac_data = IDLE_CODE, o_underrun = 0.
  - FIFO emptied: rd/wr pointers = 0, o_level = 0, o_ready = 1.
  - Reset mid-transfer discards buffered words; no partial output.
- Divider:
  - When i_en=1: cnt increments each cycle and wraps CLK_DIV-1 -> 0.
  - o_dac_clk = 0 while cnt in [0, HALF-1]; o_dac_clk = 1 while cnt in [HALF, CLK_DIV-1]. Both are flops, kept consistent.
  - When i_en=0: cnt forced to 0, o_dac_clk = 0, no pops, no underrun pulses. o_dac_data holds its value.
  - When i_en rises, the first slot occurs at the first 0 -> ... -> CLK_DIV-1 -> 0 wrap.
- Sample slot:
  - A slot is the edge at which cnt goes CLK_DIV-1 -> 0 with i_en=1; this is the same edge at which o_dac_clk falls.
  - If the FIFO is non-empty (registered count before the edge): o_dac_data <= FIFO head, rd pointer advances.
  - If the FIFO is empty: o_dac_data holds its last value and o_underrun = 1 for exactly the one following cycle.
  - Setup to the DAC rising edge = HALF system clocks. Data is stable for a full DAC period.
- FIFO:
  - Push when i_valid & o_ready.
  - o_ready = (o_level != 2**ADDR_W), a combinational decode of the registered level.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
  - A word pushed in a cycle is not visible to a slot at that same edge; an empty FIFO at a slot edge underruns even with a simultaneous push.
  - Full: o_ready = 0; i_data is ignored and no overwrite occurs.
  - Pointers wrap modulo 2**ADDR_W. Ordering is strictly first-in first-out.
  - o_level updates one edge after the push/pop.
- Latency: a word pushed into an empty FIFO appears on o_dac_data at the first slot edge strictly after the push edge. The DAC latches it HALF cycles later.
- Arithmetic:
  - o_level is ADDR_W+1 bits, so full = 2**ADDR_W is distinguishable from empty.
  - No saturation is needed beyond the full/empty guards.

Test Plan:
- Reset: hold i_rst 3 cycles with i_en=1 and i_valid=1 -> o_dac_data=8'h80, o_dac_clk=0, o_level=0, o_ready=1, o_underrun=0. Release reset -> o_dac_clk pattern 0,0,1,1 repeating (CLK_DIV=4).
- Stream: push 8'h10, 8'h20, 8'h30 back-to-back while i_en=1 -> o_dac_data takes 10, 20, 30 on consecutive o_dac_clk falling edges. Each value is stable 2 cycles before the rising edge; o_level goes 1,2,3 then decrements once per slot.
- Full: i_en=0, push 9 words 8'h01..8'h09 -> o_ready drops after the 8th word, o_level=8, 8'h09 is dropped. Then set i_en=1 -> output sequence is 01..08, then underrun.
- Underrun: i_en=1 with the FIFO empty -> o_underrun pulses 1 cycle per DAC period, o_dac_data holds the last code. Push at a slot edge -> that slot still underruns; the word appears at the next slot.
- Simultaneous push/pop: o_level=4, push at a slot edge -> o_level stays 4, FIFO order preserved.
- Reset mid-stream: o_level=5 with o_dac_clk high, assert i_rst 1 cycle -> next cycle o_level=0, o_dac_data=8'h80, o_dac_clk=0, cnt restarts at 0.
